// File: rtl/data_mem_ctrl_if.sv
// Memory-side bus between the L1 data cache (master) and the backing
// memory controller (slave). Lanes are big-endian: lane 0 = MSB byte.
interface data_mem_if;
  logic             req;
  logic             write_en;
  logic [31:0]      address;
  logic [0:3][7:0]  mem_data_in;
  logic [0:3][7:0]  mem_data_out;
  logic             busy;
  logic             done;

  modport master (
    output req, write_en, address, mem_data_in,
    input  mem_data_out, busy, done
  );

  modport slave (
    input  req, write_en, address, mem_data_in,
    output mem_data_out, busy, done
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Fixed-latency backing data memory. One request in flight at a time;
// completion is flagged by a single-cycle done pulse LATENCY cycles after
// acceptance. Writes commit and reads capture on the edge entering DONE.
module data_mem_ctrl #(
  parameter int MEM_BYTES = 65536,
  parameter int LATENCY   = 4
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [0:3][7:0] wdata_q;
  logic [0:3][7:0] rdata_q;
  logic            accept;
  logic            commit;

  // Storage has no reset: contents survive a reset pulse.
  logic [7:0]      mem [MEM_BYTES];

  // Only address bits [AW-1:2] select storage; the rest wrap or are ignored.
  logic            unused_addr;
  assign unused_addr = ^bus.address;

  // Next-state logic; a new request may be taken in IDLE or in the DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (bus.req) accept = 1'b1;
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (bus.req) accept = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = BUSY;
      cnt_d   = CW'(LATENCY - 1);
    end
  end

  // State, counter and latched request; reset aborts any in-flight op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= {bus.address[AW-1:2], 2'b00};
        we_q    <= bus.write_en;
        wdata_q <= bus.mem_data_in;
      end
    end
  end

  // Write commit on the edge entering DONE; word-aligned base never wraps mid-word.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      for (int k = 0; k < 4; k++) mem[addr_q + AW'(k)] <= wdata_q[k];
    end
  end

  // Read data register: loaded only when a read completes, held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (commit && !we_q) begin
      for (int k = 0; k < 4; k++) rdata_q[k] <= mem[addr_q + AW'(k)];
    end
  end

  assign bus.mem_data_out = rdata_q;
  assign bus.busy         = (state_q == BUSY);
  assign bus.done         = (state_q == DONE);
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded bench for data_mem_ctrl: the driver predicts acceptance from
// the timing rules and queues each accepted op; the monitor checks busy/done
// every cycle and compares read data against a byte-array memory model.
module tb_data_mem_ctrl;
  localparam int MB  = 65536;
  localparam int LAT = 4;

  typedef struct {
    bit              we;
    int unsigned     base;
    logic [0:3][7:0] data;
    int unsigned     acc;
    int unsigned     dn;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  data_mem_if bus ();

  data_mem_ctrl #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned ec = 0;        // rising edges seen so far
  int unsigned free_at = 0;   // first edge at which a new request is accepted
  op_t         q[$];
  logic [7:0]  mdl [MB];
  logic [0:3][7:0] last_rd = '0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, ec, act, exp);
    end
  endtask

  // One cycle of stimulus; predicts whether the upcoming edge accepts.
  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [0:3][7:0] d);
    op_t o;
    @(negedge clk);
    bus.req = r; bus.write_en = w; bus.address = a; bus.mem_data_in = d;
    if (r && rst_n && (ec + 1) >= free_at) begin
      o.we   = w;
      o.base = (a & 32'hFFFF_FFFC) % MB;
      o.data = d;
      o.acc  = ec + 1;
      o.dn   = ec + 1 + LAT;
      q.push_back(o);
      free_at = ec + 2 + LAT;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = 1'b0;
    q.delete();
    last_rd = '0;
    free_at = 0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: sampled 2 time units after each rising edge.
  always begin
    logic exp_busy, exp_done;
    logic [0:3][7:0] rd;
    @(posedge clk); #2;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    if (q.size() > 0) begin
      exp_busy = (ec >= q[0].acc) && (ec < q[0].dn);
      exp_done = (ec == q[0].dn);
    end
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("done", 32'(bus.done), 32'(exp_done));
    if (exp_done) begin
      op_t o;
      o = q.pop_front();
      if (o.we) begin
        for (int k = 0; k < 4; k++) mdl[(o.base + k) % MB] = o.data[k];
      end else begin
        for (int k = 0; k < 4; k++) rd[k] = mdl[(o.base + k) % MB];
        last_rd = rd;
      end
    end
    chk("rdata", bus.mem_data_out, last_rd);
  end

  initial begin
    for (int i = 0; i < MB; i++) mdl[i] = 8'h00;
    bus.req = 1'b0; bus.write_en = 1'b0; bus.address = '0; bus.mem_data_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // reset then idle
    idle(10);
    // write then read with ignored low address bits
    cyc(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    idle(6);
    cyc(1'b1, 1'b0, 32'h0000_0013, 32'h0);
    idle(6);
    // sustained req: reads of address 0, extras ignored while busy
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'h0, $urandom);
    idle(4);
    // wrap-around
    cyc(1'b1, 1'b1, 32'h0001_0008, 32'h1122_3344);
    idle(6);
    cyc(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    idle(6);
    // reset mid-write: the write must not commit
    cyc(1'b1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD);
    idle(2);
    do_reset(2);
    idle(2);
    cyc(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    idle(6);
    // back-to-back: read accepted in the write's DONE cycle sees new data
    cyc(1'b1, 1'b1, 32'h0000_0040, 32'h0102_0304);
    idle(4);
    cyc(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    idle(6);
    // randomized traffic over a small address window, with wrap aliases
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'h0003_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      cyc(($urandom % 3) != 0, $urandom % 2 == 1, a, $urandom);
      if (i == 300) do_reset(1);
    end
    idle(LAT + 4);
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
